range_coalesce_drain: RTL and testbench
=======================================

# range_coalesce_drain

Read-side drain for the sorted tuple banks. After the merge-sort phases finish, this block walks the final sorted stream of `tuple_pair_t` ranges out of the even/odd banks and coalesces overlapping or adjacent inclusive ranges into disjoint ranges. It emits the disjoint ranges on a valid/ready stream and accumulates the merged-range count and total covered length, which is the final answer path.

## Interface
- FIELD_W, 64, width of each `tuple_pair_t` field (`lo`, `hi`), unsigned; `lo` is the most significant half.
- TOTAL_W, 72, width of `total_out` accumulator.
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- start_in  in  1  one-cycle pulse, begins a drain; ignored unless idle
- stream_len_in  in  32  tuple count in the bank; sampled on accepted start_in
- even_data_in  in  2*FIELD_W  tuple at read address, valid the cycle after read_en_out
- odd_data_in  in  2*FIELD_W  tuple at read address + 1, same timing
- read_addr_out  out  `BANK_ADDR_WIDTH`  tuple index, always even
- read_en_out  out  1  read strobe
- range_out  out  2*FIELD_W  coalesced range {lo, hi}
- range_valid_out  out  1  range_out valid
- range_ready_in  in  1  downstream accepts when valid && ready
- count_out  out  32  number of ranges emitted this drain
- total_out  out  TOTAL_W  sum of (hi - lo + 1) over emitted ranges
- busy_out  out  1  high from accepted start until done
- done_out  out  1  one-cycle pulse at drain end

## Operation
- States: IDLE, FETCH, CAPTURE, EVEN, ODD, FLUSH, DONE.
- IDLE: on start_in, latch len, idx=0, clear count/total/have_cur. Go to DONE if len==0, otherwise go to FETCH.
- FETCH: read_en_out=1, read_addr_out=idx. Go to CAPTURE.
- CAPTURE: register even/odd data into a pair buffer. Go to EVEN.
- EVEN/ODD: process buffer tuple t at index idx, respectively idx+1.
  - Tuple with hi<lo: dropped, no state change.
  - No current range: cur=t, have_cur=1.
  - t.lo <= cur.hi+1, computed at FIELD_W+1 bits so cur.hi = all-ones does not wrap: merge, cur.hi = max(cur.hi, t.hi).
  - Otherwise: emit cur, then cur=t.
- EVEN next: ODD if idx+1 < len, else FLUSH.
- ODD next: idx+=2, then FETCH if idx < len, else FLUSH.
- Emit rule:
  - Output register loads cur when empty or when accepted the same cycle.
  - If the register is full and not accepted, the state holds (stall) with no tuple consumed.
  - On load: count+=1, total += cur.hi - cur.lo + 1, zero-extended to TOTAL_W, wraps modulo 2^TOTAL_W.
- FLUSH: emit cur if have_cur (stall rule applies), then wait until the output register drains. Go to DONE.
- DONE: done_out=1 for one cycle, busy_out=0 next. Go to IDLE.
- Words beyond len, including the all-ones padding, are never interpreted. An odd len ignores odd_data_in of the last read.
- Input must be sorted ascending by lo. Unsorted input yields defined but unspecified ranges; there is no error flag.

## Timing
- Reset: all outputs 0 (read_en_out, read_addr_out, range_out, range_valid_out, count_out, total_out, busy_out, done_out). State IDLE, have_cur=0.
- Reset mid-drain aborts immediately. No done_out pulse, and the output register is cleared.
- Read latency: exactly 1 cycle. Data presented the cycle after read_en_out is captured unconditionally.
- Unstalled throughput: 2 tuples per 4 cycles (FETCH, CAPTURE, EVEN, ODD).
- busy_out rises the cycle after start_in.
- count_out/total_out update the cycle the range loads into the output register. They hold after done until the next start.
- range_valid_out stays high with range_out stable until accepted.
- start_in while busy: ignored. start_in in the DONE cycle: ignored.
- Minimum drain with len==0: start, then DONE, with done_out 2 cycles after start_in.

## Test plan
- len=4, {3,5},{10,14},{12,18},{16,20}, ready=1: ranges {3,5},{10,20}; count=2; total=14; done_out once.
- len=3, {1,2},{3,4},{9,9} (adjacent and odd len): {1,4},{9,9}; total=5; second read's odd word never used.
- len=0: no read_en_out, no range_valid_out, done_out 2 cycles after start, count=total=0.
- Backpressure, ready held low for 10 cycles during 6 disjoint ranges: range_out stable while valid, no ranges lost, final count=6.
- Edge: {0, 2^64-1} followed by {5,7}: single range {0,2^64-1}, no wrap in the adjacency test, total=2^64.
- Reset asserted in ODD mid-drain, then new start with len=2, {1,1},{1,1}: outputs 0 after reset; then {1,1}, count=1, total=1.

Source files
------------

// File: rtl/range_coalesce_drain.sv
// Purpose: drains the sorted tuple banks and coalesces overlapping/adjacent inclusive ranges.
// Latency: 1-cycle bank read, 4 cycles per tuple pair when unstalled; ranges appear 1 cycle after they close.
// Backpressure: single output register; when it is full and not accepted the walker stalls without consuming a tuple.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   start_in, stream_len_in drain request and tuple count (sampled when accepted in IDLE)
//   even_data_in/odd_data_in tuples at read_addr_out and read_addr_out+1, valid the cycle after read_en_out
//   read_addr_out/read_en_out bank read port (address always even)
//   range_out/range_valid_out/range_ready_in  coalesced {lo, hi} stream
//   count_out/total_out     ranges emitted and total covered length this drain
//   busy_out/done_out       drain in progress / one-cycle end pulse
module range_coalesce_drain #(
    parameter int FIELD_W         = 64,
    parameter int TOTAL_W         = 72,
    parameter int BANK_ADDR_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_in,
    input  logic [31:0]                stream_len_in,
    input  logic [2*FIELD_W-1:0]       even_data_in,
    input  logic [2*FIELD_W-1:0]       odd_data_in,
    output logic [BANK_ADDR_WIDTH-1:0] read_addr_out,
    output logic                       read_en_out,
    output logic [2*FIELD_W-1:0]       range_out,
    output logic                       range_valid_out,
    input  logic                       range_ready_in,
    output logic [31:0]                count_out,
    output logic [TOTAL_W-1:0]         total_out,
    output logic                       busy_out,
    output logic                       done_out
);

    // lo occupies the most significant half of every bus word.
    typedef struct packed {
        logic [FIELD_W-1:0] lo;
        logic [FIELD_W-1:0] hi;
    } tuple_pair_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_EVEN,
        S_ODD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] len;
    // One bit wider than len so idx+2 never wraps near the top of the range.
    logic [32:0] idx;
    tuple_pair_t buf_even;
    tuple_pair_t buf_odd;
    tuple_pair_t cur;
    logic        have_cur;

    tuple_pair_t          proc_tuple;
    logic                 tuple_bad;
    logic [FIELD_W:0]     cur_hi_plus1;
    logic                 joins;
    logic                 out_free;
    logic                 need_emit;
    logic                 stall;
    logic                 load_out;
    logic [FIELD_W-1:0]   merged_hi;
    logic [TOTAL_W-1:0]   cur_len;
    logic [32:0]          idx_plus1;
    logic [32:0]          idx_plus2;
    logic                 more_odd;
    logic                 more_fetch;

    always_comb begin
        proc_tuple   = (state == S_ODD) ? buf_odd : buf_even;
        tuple_bad    = proc_tuple.hi < proc_tuple.lo;
        // Extra bit keeps an all-ones cur.hi from wrapping to zero in the adjacency test.
        cur_hi_plus1 = {1'b0, cur.hi} + {{FIELD_W{1'b0}}, 1'b1};
        joins        = {1'b0, proc_tuple.lo} <= cur_hi_plus1;
        merged_hi    = (proc_tuple.hi > cur.hi) ? proc_tuple.hi : cur.hi;
        // Output register can take a new range if empty or being accepted this cycle.
        out_free     = !range_valid_out || range_ready_in;
        need_emit    = have_cur && !tuple_bad && !joins;
        stall        = need_emit && !out_free;
        load_out     = 1'b0;
        if ((state == S_EVEN) || (state == S_ODD)) begin
            load_out = need_emit && out_free;
        end else if (state == S_FLUSH) begin
            load_out = have_cur && out_free;
        end
        cur_len    = TOTAL_W'(cur.hi) - TOTAL_W'(cur.lo) + TOTAL_W'(1);
        idx_plus1  = idx + 33'd1;
        idx_plus2  = idx + 33'd2;
        more_odd   = idx_plus1 < {1'b0, len};
        more_fetch = idx_plus2 < {1'b0, len};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            len             <= '0;
            idx             <= '0;
            buf_even        <= '0;
            buf_odd         <= '0;
            cur             <= '0;
            have_cur        <= 1'b0;
            read_addr_out   <= '0;
            read_en_out     <= 1'b0;
            range_out       <= '0;
            range_valid_out <= 1'b0;
            count_out       <= '0;
            total_out       <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            read_en_out <= 1'b0;
            done_out    <= 1'b0;

            // Output register: drain on handshake, a same-cycle load below overrides.
            if (range_valid_out && range_ready_in) begin
                range_valid_out <= 1'b0;
            end
            if (load_out) begin
                range_out       <= cur;
                range_valid_out <= 1'b1;
                count_out       <= count_out + 32'd1;
                total_out       <= total_out + cur_len;
            end

            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        len       <= stream_len_in;
                        idx       <= '0;
                        count_out <= '0;
                        total_out <= '0;
                        have_cur  <= 1'b0;
                        busy_out  <= 1'b1;
                        if (stream_len_in == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            state         <= S_FETCH;
                            read_en_out   <= 1'b1;
                            read_addr_out <= '0;
                        end
                    end
                end

                S_FETCH: begin
                    state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    // Bank data is valid now, one cycle after the strobe.
                    buf_even <= even_data_in;
                    buf_odd  <= odd_data_in;
                    state    <= S_EVEN;
                end

                S_EVEN, S_ODD: begin
                    if (!stall) begin
                        if (!tuple_bad) begin
                            if (!have_cur) begin
                                cur      <= proc_tuple;
                                have_cur <= 1'b1;
                            end else if (joins) begin
                                cur.hi <= merged_hi;
                            end else begin
                                // Old cur was loaded into the output register above.
                                cur <= proc_tuple;
                            end
                        end
                        if (state == S_EVEN) begin
                            // An odd len leaves the last odd word unread.
                            state <= more_odd ? S_ODD : S_FLUSH;
                        end else begin
                            idx <= idx_plus2;
                            if (more_fetch) begin
                                state         <= S_FETCH;
                                read_en_out   <= 1'b1;
                                read_addr_out <= idx_plus2[BANK_ADDR_WIDTH-1:0];
                            end else begin
                                state <= S_FLUSH;
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    if (have_cur) begin
                        if (out_free) begin
                            have_cur <= 1'b0;
                        end
                    end else if (out_free) begin
                        // Register is empty or empties at this edge.
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_range_coalesce_drain.sv
module tb_range_coalesce_drain;

    logic         clock;
    logic         reset;
    logic         start_in;
    logic [31:0]  stream_len_in;
    logic [127:0] even_data_in;
    logic [127:0] odd_data_in;
    logic [15:0]  read_addr_out;
    logic         read_en_out;
    logic [127:0] range_out;
    logic         range_valid_out;
    logic         range_ready_in;
    logic [31:0]  count_out;
    logic [71:0]  total_out;
    logic         busy_out;
    logic         done_out;

    range_coalesce_drain #(
        .FIELD_W        (64),
        .TOTAL_W        (72),
        .BANK_ADDR_WIDTH(16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start_in       (start_in),
        .stream_len_in  (stream_len_in),
        .even_data_in   (even_data_in),
        .odd_data_in    (odd_data_in),
        .read_addr_out  (read_addr_out),
        .read_en_out    (read_en_out),
        .range_out      (range_out),
        .range_valid_out(range_valid_out),
        .range_ready_in (range_ready_in),
        .count_out      (count_out),
        .total_out      (total_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    int vectors = 0;
    int miscompares = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    logic [127:0] mem [0:31];
    logic [127:0] exp_q [$];

    logic         was_stalled = 1'b0;
    logic [127:0] prev_range = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [127:0] tp(input logic [63:0] lo, input logic [63:0] hi);
        return {lo, hi};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bank model: one-cycle read latency, unwritten words are all-ones padding.
    always @(posedge clock) begin
        if (read_en_out) begin
            even_data_in <= mem[int'(read_addr_out[4:0])];
            odd_data_in  <= mem[int'(read_addr_out[4:0]) + 1];
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stability while stalled.
    always @(negedge clock) begin
        if (!reset) begin
            if (read_en_out) rd_cnt++;
            if (done_out) done_cnt++;
            if (range_valid_out) begin
                if (was_stalled) check("range_stable", range_out, prev_range);
                if (range_ready_in) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_range", range_out, 128'hx);
                    end else begin
                        check("range", range_out, exp_q.pop_front());
                    end
                end
            end
            was_stalled = range_valid_out && !range_ready_in;
            prev_range  = range_out;
        end else begin
            was_stalled = 1'b0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '1;
    endtask

    task automatic pulse_start(input logic [31:0] len);
        @(posedge clock); #1;
        stream_len_in = len;
        start_in = 1'b1;
        @(posedge clock); #1;
        start_in = 1'b0;
    endtask

    task automatic run_drain(input string name, input logic [31:0] len, input logic [31:0] exp_count,
                             input logic [71:0] exp_total, input int exp_reads, output int cycles);
        int rd0;
        int dn0;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        pulse_start(len);
        check({name, "_busy_rise"}, 128'(busy_out), 128'(1));
        cycles = 0;
        while (!done_out && cycles < 300) begin
            @(posedge clock); #1;
            cycles++;
        end
        check({name, "_done_seen"}, 128'(done_out), 128'(1));
        check({name, "_busy_at_done"}, 128'(busy_out), 128'(0));
        check({name, "_count"}, 128'(count_out), 128'(exp_count));
        check({name, "_total"}, 128'(total_out), 128'(exp_total));
        @(posedge clock); #1;
        check({name, "_done_pulse_end"}, 128'(done_out), 128'(0));
        check({name, "_done_pulses"}, 128'(done_cnt - dn0), 128'(1));
        check({name, "_reads"}, 128'(rd_cnt - rd0), 128'(exp_reads));
        check({name, "_count_hold"}, 128'(count_out), 128'(exp_count));
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start_in = 1'b0;
        stream_len_in = '0;
        range_ready_in = 1'b1;
        even_data_in = '0;
        odd_data_in = '0;
        clear_mem();
        repeat (3) @(posedge clock);
        #1;
        check("rst_read_en", 128'(read_en_out), 128'(0));
        check("rst_read_addr", 128'(read_addr_out), 128'(0));
        check("rst_range", range_out, 128'(0));
        check("rst_valid", 128'(range_valid_out), 128'(0));
        check("rst_count", 128'(count_out), 128'(0));
        check("rst_total", 128'(total_out), 128'(0));
        check("rst_busy", 128'(busy_out), 128'(0));
        check("rst_done", 128'(done_out), 128'(0));
        reset = 1'b0;

        // Overlap merge: {3,5} alone, {10,14}+{12,18}+{16,20} -> {10,20}; 3 + 11 = 14.
        clear_mem();
        mem[0] = tp(3, 5); mem[1] = tp(10, 14); mem[2] = tp(12, 18); mem[3] = tp(16, 20);
        exp_q.push_back(tp(3, 5));
        exp_q.push_back(tp(10, 20));
        run_drain("overlap", 4, 2, 14, 2, cyc);

        // Adjacent merge and odd len: padding at index 3 must never become a range.
        clear_mem();
        mem[0] = tp(1, 2); mem[1] = tp(3, 4); mem[2] = tp(9, 9);
        exp_q.push_back(tp(1, 4));
        exp_q.push_back(tp(9, 9));
        run_drain("adjacent", 3, 2, 5, 2, cyc);

        // Empty drain: done two cycles after start, no reads.
        run_drain("empty", 0, 0, 0, 0, cyc);
        check("empty_done_latency", 128'(cyc), 128'(1));

        // Backpressure over 6 disjoint ranges, plus an ignored start while busy.
        clear_mem();
        mem[0] = tp(0, 0);   mem[1] = tp(2, 3);   mem[2] = tp(5, 5);
        mem[3] = tp(10, 12); mem[4] = tp(20, 20); mem[5] = tp(30, 31);
        exp_q.push_back(tp(0, 0));   exp_q.push_back(tp(2, 3));   exp_q.push_back(tp(5, 5));
        exp_q.push_back(tp(10, 12)); exp_q.push_back(tp(20, 20)); exp_q.push_back(tp(30, 31));
        range_ready_in = 1'b0;
        fork
            run_drain("backpressure", 6, 6, 10, 3, cyc);
            begin
                repeat (4) @(posedge clock);
                #1 start_in = 1'b1;
                @(posedge clock);
                #1 start_in = 1'b0;
                repeat (6) @(posedge clock);
                #1 range_ready_in = 1'b1;
            end
        join

        // Full-width range absorbs the next tuple without wrapping; length is 2^64.
        clear_mem();
        mem[0] = tp(64'h0, 64'hFFFF_FFFF_FFFF_FFFF); mem[1] = tp(5, 7);
        exp_q.push_back(tp(64'h0, 64'hFFFF_FFFF_FFFF_FFFF));
        run_drain("fullwidth", 2, 1, 72'h01_0000_0000_0000_0000, 1, cyc);

        // Reset during ODD aborts with no emission and no done pulse.
        clear_mem();
        mem[0] = tp(1, 2); mem[1] = tp(10, 11); mem[2] = tp(20, 21); mem[3] = tp(30, 31);
        cyc = done_cnt;
        pulse_start(4);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check("abort_valid", 128'(range_valid_out), 128'(0));
        check("abort_range", range_out, 128'(0));
        check("abort_busy", 128'(busy_out), 128'(0));
        check("abort_count", 128'(count_out), 128'(0));
        check("abort_total", 128'(total_out), 128'(0));
        check("abort_read_en", 128'(read_en_out), 128'(0));
        reset = 1'b0;
        check("abort_no_done", 128'(done_cnt - cyc), 128'(0));

        clear_mem();
        mem[0] = tp(1, 1); mem[1] = tp(1, 1);
        exp_q.push_back(tp(1, 1));
        run_drain("after_abort", 2, 1, 1, 1, cyc);

        repeat (4) @(posedge clock);
        #1;
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
